shared_timer_arb: RTL and testbench



---
 rtl/shared_timer_pkg.sv | 18 +
 rtl/shared_timer_arb_rr_arbiter.sv | 32 +++
 rtl/shared_timer_arb.sv | 125 ++++++++++++
 tb/tb_shared_timer_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/shared_timer_pkg.sv
// Shared definitions for the shared prescaled timer and its round-robin arbiter.
package shared_timer_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(v)), but never below one bit so registers stay legal for tiny values.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/shared_timer_arb_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
module rr_arbiter
    import shared_timer_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr_i) + off) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/shared_timer_arb.sv
// One prescaled down-counting timer shared round-robin among N_REQ requesters.
// Define SHARED_TIMER_REMAIN_EN to expose the remaining-tick counter on port remain.
module shared_timer_arb
    import shared_timer_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PRESCALE = 50_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] delay,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy
`ifdef SHARED_TIMER_REMAIN_EN
    ,
    output logic [CNT_W-1:0]       remain
`endif
);

    localparam int PW = clog2_min1(PRESCALE);
    localparam int IW = clog2_min1(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    winner_q, winner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [N_REQ-1:0] arb_win;
    logic [IW-1:0]    arb_idx;
    logic [CNT_W-1:0] delay_arr [N_REQ];
    logic             tick;
    logic [IW-1:0]    next_ptr;

    for (genvar g = 0; g < N_REQ; g++) begin : g_delay
        assign delay_arr[g] = delay[g*CNT_W +: CNT_W];
    end

    rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (arb_win),
        .idx_o (arb_idx)
    );

    assign tick     = (presc_q == PW'(PRESCALE - 1));
    assign next_ptr = (winner_q == IW'(N_REQ - 1)) ? '0 : winner_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            winner_q <= '0;
            ptr_q    <= '0;
            presc_q  <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            presc_q  <= presc_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        presc_d  = presc_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = RUN;
                    gnt_d    = arb_win;
                    winner_d = arb_idx;
                    rem_d    = delay_arr[arb_idx];
                    presc_d  = '0;
                end
            end
            RUN: begin
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick && rem_q != '0) begin
                    rem_d = rem_q - 1'b1;
                end
                // A dropped request beats a simultaneous expiry: no done pulse.
                if (!(|(req & gnt_q))) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    presc_d = '0;
                    rem_d   = '0;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                    presc_d = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                ptr_d   = next_ptr;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign gnt  = (state_q == RUN)  ? gnt_q : '0;
    assign done = (state_q == DONE) ? gnt_q : '0;
    assign busy = (state_q == RUN);

`ifdef SHARED_TIMER_REMAIN_EN
    assign remain = (state_q == RUN) ? rem_q : '0;
`endif

endmodule

// File: tb/tb_shared_timer_arb.sv
// Directed bench for shared_timer_arb with PRESCALE=4, N_REQ=4, CNT_W=8.
module tb_shared_timer_arb;

    localparam int N = 4;
    localparam int W = 8;
    localparam int P = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
`ifdef SHARED_TIMER_REMAIN_EN
    logic [W-1:0]   remain;
`endif

    always #5 clk = ~clk;

    shared_timer_arb #(.N_REQ(N), .CNT_W(W), .PRESCALE(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .delay (delay),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy)
`ifdef SHARED_TIMER_REMAIN_EN
        ,
        .remain(remain)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (gnt == '0) check("grant_timeout", 32'(cyc), 0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done == '0 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            check("gnt_onehot", 32'($onehot0(gnt)), 1);
        end
        if (done == '0) check("done_timeout", 32'(cyc), 0);
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] dly;
        logic [N-1:0]   exp_gnt;
        int             exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int c;
        vecs[0] = '{4'b0001, 32'h00_00_00_03, 4'b0001, 13};
        vecs[1] = '{4'b0100, 32'h05_00_09_05, 4'b0100, 1};
        vecs[2] = '{4'b0011, 32'h07_07_01_02, 4'b0001, 9};
        vecs[3] = '{4'b1010, 32'h03_06_02_06, 4'b0010, 9};
        vecs[4] = '{4'b1001, 32'h01_07_07_04, 4'b1000, 5};
        vecs[5] = '{4'b1000, 32'h00_03_03_03, 4'b1000, 1};
        vecs[6] = '{4'b0110, 32'h09_02_04_09, 4'b0010, 17};
        vecs[7] = '{4'b1111, 32'h03_01_03_03, 4'b0100, 5};

        rst   = 1'b1;
        req   = '0;
        delay = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Table: pointer rotation is encoded in the expected winners.
        for (int i = 0; i < 8; i++) begin
            req   = vecs[i].req;
            delay = vecs[i].dly;
            wait_grant(c);
            check("grant_lat", 32'(c), 1);
            check("gnt", 32'(gnt), 32'(vecs[i].exp_gnt));
            check("busy_run", 32'(busy), 1);
            delay = '1;
            wait_done(c);
            check("done_lat", 32'(c), 32'(vecs[i].exp_lat));
            check("done", 32'(done), 32'(vecs[i].exp_gnt));
            check("busy_at_done", 32'(busy), 0);
            check("gnt_at_done", 32'(gnt), 0);
            req = '0;
            @(negedge clk);
            check("done_one_cycle", 32'(done), 0);
        end

        // Abort: requester 1 drops mid-run, requester 2 is then served.
        req   = 4'b0110;
        delay = 32'h00_01_0A_00;
        wait_grant(c);
        check("abort_gnt", 32'(gnt), 32'h2);
        repeat (6) @(negedge clk);
        check("abort_busy_before", 32'(busy), 1);
        req = 4'b0100;
        @(negedge clk);
        check("abort_gnt_clear", 32'(gnt), 0);
        check("abort_busy_clear", 32'(busy), 0);
        check("abort_no_done", 32'(done), 0);
        @(negedge clk);
        check("abort_next_gnt", 32'(gnt), 32'h4);
        check("abort_no_done2", 32'(done), 0);
        wait_done(c);
        check("abort_next_lat", 32'(c), 5);
        check("abort_next_done", 32'(done), 32'h4);
        req = '0;
        @(negedge clk);

        // Drop coinciding with expiry (delay 0): abort wins.
        req   = 4'b0001;
        delay = '0;
        wait_grant(c);
        check("expiry_abort_gnt", 32'(gnt), 32'h1);
        req = '0;
        @(negedge clk);
        check("expiry_abort_gnt0", 32'(gnt), 0);
        check("expiry_abort_done0", 32'(done), 0);
        @(negedge clk);
        check("expiry_abort_done1", 32'(done), 0);

        // Async reset in the middle of a run.
        req   = 4'b0100;
        delay = 32'h00_14_00_00;
        wait_grant(c);
        check("rstrun_gnt", 32'(gnt), 32'h4);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rstrun_gnt0", 32'(gnt), 0);
        check("rstrun_busy0", 32'(busy), 0);
        check("rstrun_done0", 32'(done), 0);
        req   = 4'b0011;
        delay = 32'h00_00_01_01;
        @(negedge clk);
        check("rstrun_hold", 32'(gnt), 0);
        rst = 1'b0;
        wait_grant(c);
        check("rstrun_lat", 32'(c), 1);
        check("rstrun_first", 32'(gnt), 32'h1);
        wait_done(c);
        check("rstrun_done_lat", 32'(c), 5);
        req = '0;
        @(negedge clk);

        // Full contention from a fresh pointer: order 0,1,2,3,0.
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        req   = 4'b1111;
        delay = 32'h01_01_01_01;
        for (int k = 0; k < 5; k++) begin
            wait_grant(c);
            check("rot_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
            wait_done(c);
            check("rot_lat", 32'(c), 5);
            check("rot_done", 32'(done), 32'(4'b0001 << (k % 4)));
        end
        req = '0;
        @(negedge clk);

`ifdef SHARED_TIMER_REMAIN_EN
        req   = 4'b0010;
        delay = 32'h00_00_02_00;
        check("remain_idle", 32'(remain), 0);
        wait_grant(c);
        check("remain_g0", 32'(remain), 2);
        repeat (3) @(negedge clk);
        check("remain_g3", 32'(remain), 2);
        @(negedge clk);
        check("remain_g4", 32'(remain), 1);
        repeat (4) @(negedge clk);
        check("remain_g8", 32'(remain), 0);
        @(negedge clk);
        check("remain_done", 32'(done), 32'h2);
        check("remain_at_done", 32'(remain), 0);
        req = '0;
        @(negedge clk);
        check("remain_idle_after", 32'(remain), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
